// File: rtl/nand_bist_pkg.sv
// nand_bist_pkg: shared types and constants for the NAND gate self-test controller.
package nand_bist_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
   localparam int NUM_VECTORS = 4;
   localparam int ERR_W = 3;
   function automatic logic nand_expected(input logic a, input logic b);
      return ~(a & b);
   endfunction
endpackage

// File: rtl/nand_bist_ctrl.sv
// nand_bist_ctrl: drives the four NAND input vectors, samples Y after a settle time, reports results.
// Optional NAND_BIST_LOOP_EN: back-to-back passes with accumulated results while start stays high.
module nand_bist_ctrl
   import nand_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             A,
   output logic             B,
   input  logic             Y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       fail_vec
);
   localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);
   state_t state, state_nxt;
   logic [3:0] cnt;
   logic last, mismatch, loop_again;
   logic [ERR_W-1:0] err_nxt;
   // {A,B} doubles as the vector index, so no separate index register is kept
   assign last = {A, B} == 2'(NUM_VECTORS - 1);
   assign mismatch = Y != nand_expected(A, B);
   assign err_nxt = (mismatch && err_count != '1) ? err_count + ERR_W'(1) : err_count;
`ifdef NAND_BIST_LOOP_EN
   assign loop_again = start;
`else
   assign loop_again = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb
      state_nxt = state == IDLE   ? (start ? SETTLE : IDLE)
                : state == SETTLE ? (cnt == 4'd0 ? SAMPLE : SETTLE)
                : (last && !loop_again) ? IDLE : SETTLE;
   always_comb
      busy = state != IDLE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         A <= 1'b0;
         B <= 1'b0;
         cnt <= 4'd0;
         done <= 1'b0;
         pass <= 1'b0;
         err_count <= '0;
         fail_vec <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  {A, B} <= 2'b00;
                  cnt <= RELOAD;
                  pass <= 1'b0;
                  err_count <= '0;
                  fail_vec <= 4'd0;
               end
            SETTLE:
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
            SAMPLE: begin
               err_count <= err_nxt;
               if (mismatch) fail_vec[{A, B}] <= 1'b1;
               cnt <= RELOAD;
               {A, B} <= last ? 2'b00 : {A, B} + 2'd1;
               if (last) begin
                  done <= 1'b1;
                  pass <= err_nxt == '0;
               end
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_nand_bist_ctrl.sv
// tb_nand_bist_ctrl: table-driven and randomized check of nand_bist_ctrl against a cycle-count model.
// The gate is modelled in the bench; define NAND_BIST_LOOP_EN to exercise looping.
module tb_nand_bist_ctrl;
   localparam int S = 2;
   localparam int P = S + 1;
`ifdef NAND_BIST_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif
   logic clk, rst_n, start, a, b, y, busy, done, pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;
   int n_vec = 0;
   int n_err = 0;
   int m_err;
   logic [3:0] m_fv;

   typedef struct {
      int mode;
      bit exp_pass;
      int exp_err;
      logic [3:0] exp_fail;
   } vec_t;
   vec_t tbl[3];

   nand_bist_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Y(y),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // start accepted on the next edge; results must read cleared afterwards
   task automatic accept();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_err = 0;
      m_fv = 4'd0;
      chk("acc_busy", busy, 1);
      chk("acc_done", done, 0);
      chk("acc_pass", pass, 0);
      chk("acc_err", err_count, 0);
      chk("acc_fail", fail_vec, 0);
   endtask

   // mode: 0 good gate, 1 Y stuck 1, 2 Y stuck 0, 3 random Y
   task automatic run_body(input int m, input bit hold);
      logic [1:0] v;
      start = hold;
      for (int n = 1; n <= 4 * P; n++) begin
         v = 2'((n - 1) / P);
         chk("ab", {a, b}, v);
         chk("busy", busy, 1);
         if (n > 1) chk("done_early", done, 0);
         y = m == 0 ? ~(a & b) : m == 1 ? 1'b1 : m == 2 ? 1'b0 : 1'($urandom_range(0, 1));
         if (n % P == 0 && y != ~(v[1] & v[0])) begin
            m_err = m_err == 7 ? 7 : m_err + 1;
            m_fv[v] = 1'b1;
         end
         @(negedge clk);
      end
      chk("done", done, 1);
      chk("busy_end", busy, int'(LOOP && hold));
      chk("ab_end", {a, b}, 0);
      chk("pass", pass, int'(m_err == 0));
      chk("err_count", err_count, m_err);
      chk("fail_vec", fail_vec, m_fv);
   endtask

   initial begin
      tbl[0] = '{0, 1'b1, 0, 4'b0000};
      tbl[1] = '{1, 1'b0, 1, 4'b1000};
      tbl[2] = '{2, 1'b0, 3, 4'b0111};
      rst_n = 1'b0;
      start = 1'b0;
      y = 1'b0;
      m_err = 0;
      m_fv = 4'd0;
      repeat (2) @(negedge clk);
      chk("rst_ab", {a, b}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_fail", fail_vec, 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         accept();
         run_body(tbl[i].mode, 1'b0);
         chk("tbl_pass", pass, tbl[i].exp_pass);
         chk("tbl_err", err_count, tbl[i].exp_err);
         chk("tbl_fail", fail_vec, tbl[i].exp_fail);
         @(negedge clk);
         chk("tbl_done_low", done, 0);
      end
`ifdef NAND_BIST_LOOP_EN
      accept();
      run_body(1, 1'b1);
      run_body(1, 1'b1);
      run_body(1, 1'b0);
      chk("loop_err", err_count, 3);
      chk("loop_fail", fail_vec, 4'b1000);
      accept();
      run_body(2, 1'b1);
      run_body(2, 1'b1);
      run_body(2, 1'b0);
      chk("loop_sat", err_count, 7);
      @(negedge clk);
`else
      accept();
      run_body(1, 1'b1);
      @(negedge clk);
      m_err = 0;
      m_fv = 4'd0;
      chk("held_busy", busy, 1);
      chk("held_ab", {a, b}, 0);
      chk("held_err", err_count, 0);
      chk("held_fail", fail_vec, 0);
      chk("held_pass", pass, 0);
      run_body(0, 1'b0);
      @(negedge clk);
`endif
      accept();
      y = 1'b1;
      repeat (2 * P + 1) @(negedge clk);
      chk("mid_ab", {a, b}, 2);
      rst_n = 1'b0;
      #1;
      chk("arst_ab", {a, b}, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_err", err_count, 0);
      chk("arst_fail", fail_vec, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_done", done, 0);
         chk("post_rst_busy", busy, 0);
      end
      accept();
      run_body(0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_ab", {a, b}, 0);
         end
         accept();
         run_body(3, 1'b0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/nand_bist_ctrl.md
# nand_bist_ctrl

Synthesizable stimulus-and-check controller that sits directly upstream and downstream of `nand_gate`. It drives `A`/`B` through the four input combinations in order 00, 01, 10, 11 and samples `Y` after a programmable settle time. It compares each sample against ~(A&B) and reports pass/fail plus per-vector failure flags. It is the on-chip counterpart to the simulation bench, used for self-test of the gate instance.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range 1..15; 4-bit counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a test pass; sampled only in IDLE.
- `A`, output, 1: registered stimulus to `nand_gate.A`.
- `B`, output, 1: registered stimulus to `nand_gate.B`.
- `Y`, input, 1: response from `nand_gate.Y`.
- `busy`, output, 1: high while a pass is running.
- `done`, output, 1: one-cycle pulse when a pass completes.
- `pass`, output, 1: high when the last completed pass had zero mismatches; held.
- `err_count`, output, 3: number of mismatching samples; saturates at 7.
- `fail_vec`, output, 4: bit i set when vector i = {A,B} mismatched.

## Operation
- States are IDLE, SETTLE and SAMPLE.
- **IDLE**
  - `A`=`B`=0, `busy`=0.
  - If `start`=1 at an edge, the controller:
    - loads vector 0,
    - clears `pass`, `err_count` and `fail_vec`,
    - loads the settle counter with SETTLE_CYCLES-1,
    - sets `busy`=1,
    - moves to SETTLE.
- **SETTLE**
  - Hold the current vector.
  - Decrement the counter; at 0, move to SAMPLE.
- **SAMPLE**, one cycle, on its closing edge:
  - compare `Y` with ~(A&B),
  - on mismatch, set `fail_vec[{A,B}]` and increment `err_count` (saturating),
  - if the vector index is below 3, advance `A`/`B` to the next vector, reload the counter and move to SETTLE,
  - if the index is 3, set `done`=1 and `busy`=0, set `pass`=(final err_count==0), drive `A`=`B`=0 and move to IDLE.
- `start` is ignored while `busy`=1.
- `start` high during the `done` cycle is accepted, because the controller is already in IDLE. This begins a new pass and clears the results on that edge.
- Results (`pass`, `err_count`, `fail_vec`) hold until the next accepted `start` or reset.
- `Y` is treated as a plain synchronous input. No synchronizer is needed; the gate shares `clk` timing through the registered `A`/`B`.

## Timing
- Reset values: `A`=0, `B`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, state IDLE.
- Each vector occupies SETTLE_CYCLES+1 cycles.
- Latency from the start-accept edge to the edge asserting `done` is 4×(SETTLE_CYCLES+1) cycles, which is 12 at the default.
- `A`/`B` change only on the start-accept edge and on SAMPLE closing edges.
- Reset asserted mid-pass:
  - immediate asynchronous abort to the reset values,
  - no `done` pulse,
  - partial results are discarded.
- `err_count` cannot exceed 4 in single-pass mode. Saturation at 7 matters only under looping.

## Configuration
- Macro `NAND_BIST_LOOP_EN`.
- Defined:
  - if `start` is still 1 at the final SAMPLE edge, `done` pulses, `busy` stays 1 and the controller reloads vector 0 directly into SETTLE without visiting IDLE,
  - `err_count` and `fail_vec` accumulate across iterations and are not cleared,
  - `pass` is updated at each `done` from the accumulated `err_count`,
  - deasserting `start` ends looping at the next pass boundary.
- Undefined: single pass per accepted `start`, exactly as described in Operation.

## Structure
- Package `nand_bist_pkg` contains:
  - the state enum (IDLE, SETTLE, SAMPLE),
  - `NUM_VECTORS`=4,
  - `ERR_W`=3,
  - function `nand_expected(a,b)` returning ~(a&b).
- Keep the block flat. The settle counter is too small to justify a sub-module.
- The bench instantiates `nand_bist_ctrl` together with `nand_gate`. A fault-injection wrapper may force `Y`.

## Test plan
- Reset, then `start` pulse, with a correct `nand_gate` and SETTLE_CYCLES=2 -> `done` 12 cycles after the accept edge, `pass`=1, `err_count`=0, `fail_vec`=4'b0000.
- `Y` forced to 1 -> only vector 11 mismatches -> `pass`=0, `err_count`=1, `fail_vec`=4'b1000.
- `Y` forced to 0 -> `err_count`=3, `fail_vec`=4'b0111.
- `start` held high throughout in a single-pass build -> `A`/`B` sequence 00,01,10,11 each held 3 cycles, one `done`, and a second pass begins on the `done` cycle with results cleared.
- `rst_n` low during vector 10 -> all outputs 0 within the same cycle, no `done`; a subsequent `start` runs a full 12-cycle pass.
- `NAND_BIST_LOOP_EN` defined, `Y` stuck at 1, `start` held for 3 passes -> three `done` pulses 12 cycles apart, `err_count`=3, `fail_vec`=4'b1000, `busy` continuously 1.
